// File: rtl/ofdm_bit_source_if.sv
// Parallel word handshake into the OFDM bit source (valid/ready).
interface ofdm_bit_source_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_valid, input  s_ready);
  modport slave  (input  s_data, input  s_valid, output s_ready);
endinterface

// File: rtl/ofdm_bit_source.sv
// OFDM bit source: buffers WIDTH-bit words in a FIFO and serializes them
// LSB-first at one bit per DIV clocks. The stream never stalls; an empty
// FIFO at a word boundary yields an idle word (zeros, or a replay of the
// last real word when OFDM_BIT_SOURCE_IDLE_REPEAT_EN is defined).
module ofdm_bit_source #(
  parameter int WIDTH      = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DIV        = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  ofdm_bit_source_if.slave            s,
  output logic                        bit_out,
  output logic                        bit_strobe,
  output logic                        sym_start,
  output logic                        bit_active,
  output logic                        underrun,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(WIDTH);
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      level_q, level_d;
  logic [DW-1:0]    div_cnt_q, div_cnt_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic [WIDTH-1:0] shreg_q, shreg_d, src, idle_word;
  logic             bit_out_q, bit_out_d, bit_active_q, bit_active_d;
  logic             bit_strobe_q, sym_start_q, underrun_q;
  logic             tick, boundary, wr, pop;

  assign tick     = (div_cnt_q == DW'(DIV - 1));
  assign boundary = tick && (bit_idx_q == '0);
  assign s.s_ready = (level_q != (PW+1)'(FIFO_DEPTH));
  assign wr       = s.s_valid && s.s_ready;
  // No fall-through: only words already stored (level_q) can be popped.
  assign pop      = boundary && (level_q != '0);

`ifdef OFDM_BIT_SOURCE_IDLE_REPEAT_EN
  logic [WIDTH-1:0] last_word_q;
  assign idle_word = last_word_q;

  // Remember the most recent boundary word so idle boundaries can replay it.
  always_ff @(posedge clk) begin
    if (reset)         last_word_q <= '0;
    else if (boundary) last_word_q <= src;
  end
`else
  assign idle_word = '0;
`endif

  // Next-state for divider, FIFO level and serializer.
  always_comb begin
    div_cnt_d    = tick ? '0 : div_cnt_q + DW'(1);
    level_d      = level_q + (PW+1)'(wr) - (PW+1)'(pop);
    src          = pop ? mem_q[rd_ptr_q] : idle_word;
    bit_idx_d    = bit_idx_q;
    shreg_d      = shreg_q;
    bit_out_d    = bit_out_q;
    bit_active_d = bit_active_q;
    if (boundary) begin
      bit_out_d    = src[0];
      shreg_d      = src >> 1;
      bit_active_d = pop;
      bit_idx_d    = IW'(1);
    end else if (tick) begin
      bit_out_d    = shreg_q[0];
      shreg_d      = shreg_q >> 1;
      bit_idx_d    = (bit_idx_q == IW'(WIDTH - 1)) ? '0 : bit_idx_q + IW'(1);
    end
  end

  // FIFO storage; pointers carry the reset, so the array needs none.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= s.s_data;
  end

  // State registers; strobe/sym_start/underrun are one-cycle pulses after a tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      div_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shreg_q      <= '0;
      bit_out_q    <= 1'b0;
      bit_active_q <= 1'b0;
      bit_strobe_q <= 1'b0;
      sym_start_q  <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      if (wr)  wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      level_q      <= level_d;
      div_cnt_q    <= div_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shreg_q      <= shreg_d;
      bit_out_q    <= bit_out_d;
      bit_active_q <= bit_active_d;
      bit_strobe_q <= tick;
      sym_start_q  <= boundary;
      underrun_q   <= boundary && !pop;
    end
  end

  assign bit_out    = bit_out_q;
  assign bit_strobe = bit_strobe_q;
  assign sym_start  = sym_start_q;
  assign bit_active = bit_active_q;
  assign underrun   = underrun_q;
  assign fifo_level = level_q;
endmodule
